// File: rtl/openila_rle_fifo.sv
// OpenILA second-generation run-length compressor: samples are encoded into
// literal/run words and buffered in a first-word-fallthrough FIFO with overflow reporting.
module openila_rle_fifo #(
   parameter  int unsigned W_SAMPLE = 8,
   parameter  int unsigned W_COUNT  = 4,
   parameter  int unsigned DEPTH    = 8,
   localparam int unsigned W_MEM    = W_SAMPLE + 1,
   localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [W_SAMPLE-1:0] din,
   input  logic                din_valid,
   input  logic                flush,
   output logic [W_MEM-1:0]    dout,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic [LW-1:0]       level,
   output logic                overflow,
   input  logic                clr_overflow
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W_MEM-1:0]    mem [DEPTH];
   logic [PW-1:0]       wptr;
   logic [PW-1:0]       rptr;
   logic [W_SAMPLE-1:0] prev;
   logic [W_COUNT-1:0]  count;
   logic                resync;

   logic [1:0]          n_req;
   logic [1:0]          n_push;
   logic [W_MEM-1:0]    w0;
   logic [W_MEM-1:0]    w1;
   logic [W_COUNT-1:0]  count_nxt;
   logic [W_COUNT-1:0]  cnt_inc;
   logic                resync_nxt;
   logic [LW-1:0]       free;
   logic                drop;
   logic                pop;

   function automatic logic [W_MEM-1:0] lit_word(input logic [W_SAMPLE-1:0] s);
      return {1'b0, s};
   endfunction

   function automatic logic [W_MEM-1:0] run_word(input logic [W_COUNT-1:0] c);
      return {1'b1, W_SAMPLE'(c)};
   endfunction

   // Encoder: decides how many words this cycle wants to push and what they are.
   always_comb begin
      n_req      = 2'd0;
      w0         = '0;
      w1         = '0;
      count_nxt  = count;
      resync_nxt = resync;
      cnt_inc    = count + W_COUNT'(1);
      if (din_valid) begin
         if (resync) begin
            n_req      = 2'd1;
            w0         = lit_word(din);
            count_nxt  = '0;
            resync_nxt = 1'b0;
         end else if (din == prev) begin
            if (cnt_inc == '1) begin
               n_req     = 2'd1;
               w0        = run_word(cnt_inc);
               count_nxt = '0;
            end else begin
               count_nxt = cnt_inc;
            end
         end else if (count == '0) begin
            n_req = 2'd1;
            w0    = lit_word(din);
         end else begin
            n_req     = 2'd2;
            w0        = run_word(count);
            w1        = lit_word(din);
            count_nxt = '0;
         end
      end else if (flush) begin
         if (count != '0) begin
            n_req = 2'd1;
            w0    = run_word(count);
         end
         count_nxt  = '0;
         resync_nxt = 1'b1;
      end
   end

   // Space is judged on the occupancy before this edge; a simultaneous pop does not help.
   always_comb begin
      free   = LW'(DEPTH) - level;
      drop   = LW'(n_req) > free;
      n_push = drop ? 2'd0 : n_req;
      pop    = dout_ready && (level != '0);
   end

   always_ff @(posedge clk) begin
      if (n_push != 2'd0) begin
         mem[wptr] <= w0;
      end
      if (n_push == 2'd2) begin
         mem[wptr + PW'(1)] <= w1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
         prev     <= '0;
         count    <= '0;
         resync   <= 1'b1;
      end else begin
         if (din_valid) begin
            prev <= din;
         end
         count  <= drop ? '0 : count_nxt;
         resync <= drop ? 1'b1 : resync_nxt;
         wptr   <= wptr + PW'(n_push);
         rptr   <= rptr + PW'(pop);
         level  <= level + LW'(n_push) - LW'(pop);
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   always_comb begin
      dout_valid = (level != '0);
      dout       = dout_valid ? mem[rptr] : '0;
   end

endmodule

// File: tb/tb_openila_rle_fifo.sv
// Directed table-driven bench for openila_rle_fifo (W_SAMPLE=8, W_COUNT=4, DEPTH=8).
module tb_openila_rle_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       flush;
   logic [8:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic [3:0] level;
   logic       overflow;
   logic       clr_overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   openila_rle_fifo #(.W_SAMPLE(8), .W_COUNT(4), .DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .din_valid    (din_valid),
      .flush        (flush),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .level        (level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   typedef struct {
      logic       rst;
      logic [7:0] din;
      logic       vld;
      logic       flush;
      logic       rdy;
      logic       clr;
      logic [8:0] e_dout;
      logic [3:0] e_level;
      logic       e_ovf;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic [7:0] d, input logic v, input logic f,
                      input logic rd, input logic c, input logic [8:0] ed,
                      input logic [3:0] el, input logic eo);
      vec_t x;
      x.rst = r; x.din = d; x.vld = v; x.flush = f; x.rdy = rd; x.clr = c;
      x.e_dout = ed; x.e_level = el; x.e_ovf = eo;
      vq.push_back(x);
   endtask

   task automatic check(input string name, input int idx, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic [7:0] d, input logic v, input logic f,
                       input logic rd, input logic c);
      rst = r; din = d; din_valid = v; flush = f; dout_ready = rd; clr_overflow = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input int idx, input logic [8:0] ed, input logic [3:0] el,
                            input logic eo);
      check("dout", idx, 16'(dout), 16'(ed));
      check("dout_valid", idx, 16'(dout_valid), 16'(el != 4'd0));
      check("level", idx, 16'(level), 16'(el));
      check("overflow", idx, 16'(overflow), 16'(eo));
   endtask

   initial begin
      rst = 1'b1; din = '0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b1;
      clr_overflow = 1'b0;

      // reset
      add(1, 8'h00, 0, 0, 1, 0, 9'h000, 0, 0);
      add(1, 8'h00, 0, 0, 1, 0, 9'h000, 0, 0);
      // 12,12,12,34: literal, then run(2) and literal in one cycle
      add(0, 8'h12, 1, 0, 1, 0, 9'h012, 1, 0);
      add(0, 8'h12, 1, 0, 1, 0, 9'h000, 0, 0);
      add(0, 8'h12, 1, 0, 1, 0, 9'h000, 0, 0);
      add(0, 8'h34, 1, 0, 1, 0, 9'h102, 2, 0);
      add(0, 8'h00, 0, 0, 1, 0, 9'h034, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 9'h000, 0, 0);
      // AA literal, 15 repeats saturate, one more, then flush
      add(0, 8'hAA, 1, 0, 1, 0, 9'h0AA, 1, 0);
      for (int i = 0; i < 14; i++) add(0, 8'hAA, 1, 0, 1, 0, 9'h000, 0, 0);
      add(0, 8'hAA, 1, 0, 1, 0, 9'h10F, 1, 0);
      add(0, 8'hAA, 1, 0, 1, 0, 9'h000, 0, 0);
      add(0, 8'h00, 0, 1, 1, 0, 9'h101, 1, 0);
      add(0, 8'h55, 1, 0, 1, 0, 9'h055, 1, 0);
      // flush with din_valid=1 is ignored: 55 counts as a repeat
      add(0, 8'h55, 1, 1, 1, 0, 9'h000, 0, 0);
      add(0, 8'h66, 1, 0, 1, 0, 9'h101, 2, 0);
      add(0, 8'h00, 0, 0, 1, 0, 9'h066, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 9'h000, 0, 0);
      // fill to 8 with no consumer, 9th sample dropped
      for (int i = 1; i <= 8; i++)
         add(0, (i % 2 == 1) ? 8'h01 : 8'h02, 1, 0, 0, 0, 9'h001, 4'(i), 0);
      add(0, 8'h01, 1, 0, 0, 0, 9'h001, 8, 1);
      for (int k = 1; k <= 8; k++)
         add(0, 8'h00, 0, 0, 1, 0, (k == 8) ? 9'h000 : ((k % 2 == 1) ? 9'h002 : 9'h001),
             4'(8 - k), 1);
      // repeat of prev after a drop must still be a literal
      add(0, 8'h01, 1, 0, 1, 0, 9'h001, 1, 1);
      add(0, 8'h00, 0, 0, 1, 1, 9'h000, 0, 0);
      // refill, drop with clr_overflow in the same cycle, then clear
      for (int i = 1; i <= 8; i++)
         add(0, (i % 2 == 1) ? 8'h02 : 8'h01, 1, 0, 0, 0, 9'h002, 4'(i), 0);
      add(0, 8'h02, 1, 0, 0, 1, 9'h002, 8, 1);
      add(0, 8'h00, 0, 0, 0, 1, 9'h002, 8, 0);
      // level 7 with a pending run, then a two-word push is dropped entirely
      add(0, 8'h00, 0, 0, 1, 0, 9'h001, 7, 0);
      add(0, 8'h00, 0, 0, 1, 0, 9'h002, 6, 0);
      add(0, 8'h33, 1, 0, 0, 0, 9'h002, 7, 0);
      add(0, 8'h33, 1, 0, 0, 0, 9'h002, 7, 0);
      add(0, 8'h44, 1, 0, 0, 0, 9'h002, 7, 1);
      add(0, 8'h44, 1, 0, 0, 0, 9'h002, 8, 1);
      // full FIFO: a same-cycle pop frees no space
      add(0, 8'h66, 1, 0, 1, 0, 9'h001, 7, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h002, 6, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h001, 5, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h002, 4, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h001, 3, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h033, 2, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h044, 1, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h000, 0, 1);
      add(0, 8'h00, 0, 0, 1, 0, 9'h000, 0, 1);

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].din, vq[i].vld, vq[i].flush, vq[i].rdy, vq[i].clr);
         check_out(i, vq[i].e_dout, vq[i].e_level, vq[i].e_ovf);
      end

      // mid-run reset discards the pending run and the sticky flag
      step(0, 8'h77, 1, 0, 1, 0);
      check_out(1000, 9'h077, 1, 1);
      for (int i = 0; i < 5; i++) step(0, 8'h77, 1, 0, 1, 0);
      check_out(1001, 9'h000, 0, 1);
      step(1, 8'h77, 1, 0, 1, 0);
      check_out(1002, 9'h000, 0, 0);
      step(0, 8'h00, 0, 1, 1, 0);
      check_out(1003, 9'h000, 0, 0);
      step(0, 8'h77, 1, 0, 1, 0);
      check_out(1004, 9'h077, 1, 0);
      step(0, 8'h88, 1, 0, 1, 0);
      check_out(1005, 9'h088, 1, 0);
      step(0, 8'h00, 0, 0, 1, 0);
      check_out(1006, 9'h000, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
